// File: rtl/state_dump_sequencer.sv
`default_nettype none
// ============================================================================
// state_dump_sequencer : streams PC, cycle count, register bank and data memory
//                        words to the UART transmitter after a halt.   rev 1.0
// ============================================================================
module state_dump_sequencer #(
    parameter int NBITS          = 32,
    parameter int RBITS          = 5,
    parameter int BANK_SIZE      = 32,
    parameter int REG_WIDTH      = 32,
    parameter int DM_ADDR_LENGTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DM_DUMP_WORDS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NBITS-1:0]          current_pc,
    input  logic [NBITS-1:0]          clock_count,
    input  logic [REG_WIDTH-1:0]      RB_Data,
    input  logic [DATA_WIDTH-1:0]     DM_Data,
    input  logic                      tx_done,
    output logic [RBITS-1:0]          RB_Addr,
    output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
    output logic [NBITS-1:0]          tx_Data,
    output logic                      tx_start,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_WORDS = (BANK_SIZE > DM_DUMP_WORDS) ? BANK_SIZE : DM_DUMP_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);

    localparam logic [IDX_W-1:0]          RB_LAST   = IDX_W'(BANK_SIZE - 1);
    localparam logic [IDX_W-1:0]          DM_LAST   = IDX_W'(DM_DUMP_WORDS - 1);
    localparam logic [DM_ADDR_LENGTH-1:0] DM_STRIDE = DM_ADDR_LENGTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_PC  = 2'd0,
        SRC_CNT = 2'd1,
        SRC_RB  = 2'd2,
        SRC_DM  = 2'd3
    } src_t;

    state_t                    state_q;
    src_t                      src_q;
    logic [IDX_W-1:0]          index_q;
    logic [NBITS-1:0]          cnt_snap_q;
    logic [RBITS-1:0]          rb_addr_q;
    logic [DM_ADDR_LENGTH-1:0] dm_addr_q;
    logic [NBITS-1:0]          tx_data_q;
    logic                      tx_start_q;
    logic                      busy_q;
    logic                      done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_PC;
            index_q    <= '0;
            cnt_snap_q <= '0;
            rb_addr_q  <= '0;
            dm_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;

            // Abort drops the dump from any active state; a word already handed
            // to the UART finishes on its own and its tx_done lands in IDLE.
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                index_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            cnt_snap_q <= clock_count;
                            tx_data_q  <= current_pc;
                            src_q      <= SRC_PC;
                            index_q    <= '0;
                            busy_q     <= 1'b1;
                            tx_start_q <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end

                    S_SEND: begin
                        state_q <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (tx_done) begin
                            case (src_q)
                                SRC_PC: begin
                                    tx_data_q  <= cnt_snap_q;
                                    src_q      <= SRC_CNT;
                                    tx_start_q <= 1'b1;
                                    state_q    <= S_SEND;
                                end
                                SRC_CNT: begin
                                    rb_addr_q <= '0;
                                    index_q   <= '0;
                                    src_q     <= SRC_RB;
                                    state_q   <= S_LOAD;
                                end
                                SRC_RB: begin
                                    if (index_q < RB_LAST) begin
                                        index_q   <= index_q + 1'b1;
                                        rb_addr_q <= rb_addr_q + 1'b1;
                                    end else begin
                                        index_q   <= '0;
                                        dm_addr_q <= '0;
                                        src_q     <= SRC_DM;
                                    end
                                    state_q <= S_LOAD;
                                end
                                SRC_DM: begin
                                    if (index_q < DM_LAST) begin
                                        index_q   <= index_q + 1'b1;
                                        dm_addr_q <= dm_addr_q + DM_STRIDE;
                                        state_q   <= S_LOAD;
                                    end else begin
                                        index_q <= '0;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                        state_q <= S_IDLE;
                                    end
                                end
                                default: state_q <= S_IDLE;
                            endcase
                        end
                    end

                    // Read ports return data for the address driven during this cycle.
                    S_LOAD: begin
                        if (src_q == SRC_RB) begin
                            tx_data_q <= NBITS'(RB_Data);
                        end else begin
                            tx_data_q <= NBITS'(DM_Data);
                        end
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND;
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign RB_Addr  = rb_addr_q;
    assign DM_Addr  = dm_addr_q;
    assign tx_Data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_state_dump_sequencer.sv
`default_nettype none
// ============================================================================
// tb_state_dump_sequencer : directed + randomized dumps against a word-list
//                           model of the expected UART stream.      rev 1.0
// ============================================================================
module tb_state_dump_sequencer;

    localparam int BANK = 32;
    localparam int DMW  = 4;
    localparam int NW   = 2 + BANK + DMW;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, tx_done = 1'b0;
    logic [31:0] current_pc = '0, clock_count = '0;
    logic [31:0] regs [BANK];
    logic [31:0] dmem [16];
    logic [31:0] rb_data, dm_data;
    logic [4:0]  rb_addr;
    logic [31:0] dm_addr, tx_data;
    logic        tx_start, busy, done;

    state_dump_sequencer #(
        .NBITS(32), .RBITS(5), .BANK_SIZE(BANK), .REG_WIDTH(32),
        .DM_ADDR_LENGTH(32), .DATA_WIDTH(32), .DM_DUMP_WORDS(DMW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .current_pc(current_pc), .clock_count(clock_count),
        .RB_Data(rb_data), .DM_Data(dm_data), .tx_done(tx_done),
        .RB_Addr(rb_addr), .DM_Addr(dm_addr), .tx_Data(tx_data),
        .tx_start(tx_start), .busy(busy), .done(done)
    );

    assign rb_data = regs[rb_addr];
    assign dm_data = dmem[dm_addr[5:2]];

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed stream, filled by the UART/monitor process only.
    logic [31:0] got_w [$];
    int          gap_q [$];
    logic [4:0]  rb_load_q [$];
    logic [4:0]  rb_send_q [$];
    logic [31:0] dm_send_q [$];
    int          cyc = 0, done_cnt = 0, done_cyc = -100, last_real_done = -100;
    int          countdown = 0, uart_lat = 10;
    bit          spurious_en = 1'b0;
    logic [4:0]  prev_rb = '0;

    logic [31:0] exp_w [NW];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start === 1'b1) begin
                got_w.push_back(tx_data);
                gap_q.push_back(cyc - last_real_done);
                rb_load_q.push_back(prev_rb);
                rb_send_q.push_back(rb_addr);
                dm_send_q.push_back(dm_addr);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_rb = rb_addr;
            tx_done = 1'b0;
            if (rst) begin
                countdown = 0;
            end else if (tx_start === 1'b1) begin
                countdown = uart_lat;
                if (spurious_en) tx_done = 1'b1;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    tx_done = 1'b1;
                    last_real_done = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected();
        exp_w[0] = current_pc;
        exp_w[1] = clock_count;
        for (int n = 0; n < BANK; n++) exp_w[2 + n] = regs[n];
        for (int m = 0; m < DMW; m++) exp_w[2 + BANK + m] = dmem[m];
    endtask

    task automatic randomize_state();
        for (int n = 0; n < BANK; n++) regs[n] = $urandom;
        for (int m = 0; m < 16; m++) dmem[m] = $urandom;
        current_pc  = $urandom;
        clock_count = $urandom;
    endtask

    task automatic pulse_start(input bit chk, input string tag);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (chk) begin
            check({tag, ".busy_after_start"}, busy, 1);
            check({tag, ".pc_tx_start"}, tx_start, 1);
            check({tag, ".pc_tx_data"}, tx_data, exp_w[0]);
        end
    endtask

    task automatic wait_words(input int n, input string tag);
        for (int k = 0; k < 2000 && got_w.size() < n; k++) @(posedge clk);
        check({tag, ".words_reached"}, got_w.size() >= n, 1);
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int k = 0; k < 4000 && done_cnt == d0; k++) @(posedge clk);
        check({tag, ".done_seen"}, done_cnt != d0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify_dump(input int base, input int d0, input string tag);
        check({tag, ".word_count"}, got_w.size() - base, NW);
        for (int i = 0; i < NW; i++) begin
            if (base + i < got_w.size()) begin
                check($sformatf("%s.word%0d", tag, i), got_w[base + i], exp_w[i]);
                if (i >= 2)
                    check($sformatf("%s.gap%0d", tag, i), gap_q[base + i], 2);
                if (i >= 2 && i < 2 + BANK) begin
                    check($sformatf("%s.rb_load%0d", tag, i), rb_load_q[base + i], i - 2);
                    check($sformatf("%s.rb_send%0d", tag, i), rb_send_q[base + i], i - 2);
                end
                if (i >= 2 + BANK)
                    check($sformatf("%s.dm_addr%0d", tag, i), dm_send_q[base + i], (i - 2 - BANK) * 4);
            end
        end
        check({tag, ".done_once"}, done_cnt - d0, 1);
        check({tag, ".done_timing"}, done_cyc, last_real_done + 1);
        check({tag, ".busy_low"}, busy, 0);
        check({tag, ".tx_start_low"}, tx_start, 0);
    endtask

    task automatic full_dump(input string tag);
        int base, d0;
        build_expected();
        base = got_w.size();
        d0   = done_cnt;
        pulse_start(1'b1, tag);
        wait_done(d0, tag);
        verify_dump(base, d0, tag);
    endtask

    initial begin
        int base, d0, nsnap;

        for (int n = 0; n < BANK; n++) regs[n] = n * 32'h11;
        for (int m = 0; m < 16; m++) dmem[m] = 32'hD000_0000 + m * 32'h0101;

        #1 rst = 1'b1;
        #11;
        check("rst.RB_Addr", rb_addr, 0);
        check("rst.DM_Addr", dm_addr, 0);
        check("rst.tx_Data", tx_data, 0);
        check("rst.tx_start", tx_start, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed dump: PC/count changed right after start must not leak in.
        current_pc  = 32'h0000_0040;
        clock_count = 32'h0000_0123;
        build_expected();
        base = got_w.size();
        d0   = done_cnt;
        pulse_start(1'b1, "d1");
        current_pc  = 32'h0000_0080;
        clock_count = 32'h0000_0999;
        wait_done(d0, "d1");
        verify_dump(base, d0, "d1");

        // Abort while waiting on r5.
        randomize_state();
        build_expected();
        base = got_w.size();
        d0   = done_cnt;
        pulse_start(1'b1, "ab");
        wait_words(base + 8, "ab");
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        check("ab.busy_fall", busy, 0);
        check("ab.tx_start_low", tx_start, 0);
        abort = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("ab.no_more_words", got_w.size(), base + 8);
        check("ab.no_done", done_cnt, d0);
        uart_lat = $urandom_range(3, 12);
        full_dump("ab_restart");

        // start and abort together in IDLE: nothing starts.
        nsnap = got_w.size();
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        check("sa.busy", busy, 0);
        check("sa.tx_start", tx_start, 0);
        repeat (20) @(posedge clk);
        check("sa.no_words", got_w.size(), nsnap);

        // Second start mid-dump and tx_done during every SEND cycle.
        randomize_state();
        uart_lat    = $urandom_range(3, 12);
        spurious_en = 1'b1;
        build_expected();
        base = got_w.size();
        d0   = done_cnt;
        pulse_start(1'b1, "sp");
        wait_words(base + 10, "sp");
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d0, "sp");
        verify_dump(base, d0, "sp");
        spurious_en = 1'b0;

        // Asynchronous reset between clock edges mid-dump.
        randomize_state();
        uart_lat = 10;
        build_expected();
        base = got_w.size();
        pulse_start(1'b1, "rs");
        wait_words(base + 20, "rs");
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rs.RB_Addr", rb_addr, 0);
        check("rs.DM_Addr", dm_addr, 0);
        check("rs.tx_Data", tx_data, 0);
        check("rs.tx_start", tx_start, 0);
        check("rs.busy", busy, 0);
        check("rs.done", done, 0);
        nsnap = got_w.size();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rs.idle_after_release", got_w.size(), nsnap);
        check("rs.busy_after_release", busy, 0);
        randomize_state();
        full_dump("rs_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/state_dump_sequencer.md
Name: state_dump_sequencer

Overview:
- Sequences a post-halt snapshot of processor state out over the UART transmitter, one word per transfer.
- Order: PC, clock count, register bank r0..r(BANK_SIZE-1), then data memory words 0..DM_DUMP_WORDS-1.
- Sits in the debug unit, between the debug controller (start/abort/done), the register-bank and data-memory debug read ports, and the UART TX (tx_start/tx_done handshake).

Parameters:
- NBITS, 32, UART word width and width of PC / clock count.
- RBITS, 5, register-bank address width.
- BANK_SIZE, 32, number of registers dumped.
- REG_WIDTH, 32, register data width (≤ NBITS, zero-extended).
- DM_ADDR_LENGTH, 32, data-memory byte-address width.
- DATA_WIDTH, 32, data-memory word width (≤ NBITS, zero-extended).
- DM_DUMP_WORDS, 16, number of data-memory words dumped (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  terminate the dump immediately, no done.
- current_pc  in  NBITS  PC value to report.
- clock_count  in  NBITS  executed-cycle count to report.
- RB_Data  in  REG_WIDTH  register read data, valid one cycle after RB_Addr.
- DM_Data  in  DATA_WIDTH  memory read data, valid one cycle after DM_Addr.
- tx_done  in  1  UART finished the current word (pulse).
- RB_Addr  out  RBITS  register read address.
- DM_Addr  out  DM_ADDR_LENGTH  memory byte address.
- tx_Data  out  NBITS  word to transmit.
- tx_start  out  1  one-cycle transmit strobe.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when the final word's tx_done is received.

Behaviour:
- All outputs are registered.
- Reset values: RB_Addr=0, DM_Addr=0, tx_Data=0, tx_start=0, busy=0, done=0; state=IDLE; index=0.
- States:
  - IDLE: start=1 → snapshot current_pc and clock_count into internal regs; tx_Data<=PC snapshot; → SEND, src=PC.
  - SEND: tx_start=1 for exactly this cycle; tx_Data stable → WAIT.
  - WAIT: tx_start=0; hold until tx_done=1, then:
    - src=PC → tx_Data<=count snapshot, → SEND, src=CNT.
    - src=CNT → RB_Addr<=0, → LOAD, src=RB.
    - src=RB, index<BANK_SIZE-1 → RB_Addr<=index+1, → LOAD.
    - src=RB, last register → DM_Addr<=0, index<=0, → LOAD, src=DM.
    - src=DM, index<DM_DUMP_WORDS-1 → DM_Addr<=(index+1)*4, → LOAD.
    - src=DM, last word → done<=1, → IDLE.
  - LOAD: address held for one cycle; tx_Data<=zero-extended RB_Data or DM_Data, sampled at the end of LOAD → SEND.
- Latency: tx_start for PC is asserted in cycle k+1 when start is sampled at edge k. Per register/memory word, tx_start is asserted 2 cycles after the tx_done that precedes it.
- Total words sent = 2 + BANK_SIZE + DM_DUMP_WORDS. Exactly one tx_start per word.
- DM_Addr is a byte address: index×(DATA_WIDTH/8), truncated to DM_ADDR_LENGTH. The index counter must not wrap before DM_DUMP_WORDS-1.
- RB_Addr and DM_Addr hold their last values in IDLE until the next dump.
- tx_done outside WAIT (including the SEND cycle) is ignored.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins, the dump does not start.
- abort in any non-IDLE state → IDLE next edge: tx_start=0, busy=0, done not pulsed, index cleared. A transfer the UART already has in flight is not recalled.
- rst asserted mid-dump → immediate return to reset values, independent of clk. After release, nothing is sent until a new start.
- PC and count are snapshotted at start. Later changes to current_pc or clock_count do not affect the sent values.

Test Plan:
- BANK_SIZE=32, DM_DUMP_WORDS=4, current_pc=0x0000_0040, clock_count=0x0000_0123, UART model returns tx_done 10 cycles after each tx_start, start pulse → exactly 38 tx_start pulses. Words 0x40, 0x123, then r0..r31 and M[0],M[4],M[8],M[12] in order; done pulses once, 1 cycle after the 38th tx_done; busy=0 thereafter.
- Register file preloaded rN=N×0x11 → word index 2+N equals N×0x11. RB_Addr=N during the LOAD and SEND cycles for word 2+N.
- Change current_pc to 0x80 one cycle after start → first word is still 0x40.
- Assert abort while waiting on r5 → tx_start never reasserts, busy falls next cycle, done stays 0. A new start later restarts from PC.
- Second start pulse mid-dump, plus spurious tx_done during a SEND cycle → both ignored; sequence and word count unchanged (38).
- Assert rst asynchronously mid-dump between clock edges → all outputs 0 immediately. A start after reset produces a full 38-word dump.
